// File: rtl/gelato_operand_bank_arbiter_pkg.sv
// ============================================================================
// gelato_types: shared operand-collector / register-file types. Rev 1.0
// ============================================================================
`default_nettype none

package gelato_types;

  localparam int NUM_WARPS      = 8;
  localparam int WARP_W         = $clog2(NUM_WARPS);
  localparam int REG_W          = 5;
  localparam int RS_W           = 2;
  localparam int NUM_THREADS    = 4;
  localparam int DATA_WIDTH     = 8;
  localparam int COLLECTOR_W    = 2;
  localparam int BANK_W         = 2;

  typedef logic [WARP_W-1:0]      warp_num_t;
  typedef logic [REG_W-1:0]       reg_num_t;
  typedef logic [RS_W-1:0]        rs_num_t;
  typedef logic [COLLECTOR_W-1:0] collector_num_t;
  typedef logic [BANK_W-1:0]      bank_num_t;
  typedef logic [NUM_THREADS-1:0] thread_mask_t;

  // Lane 0 occupies the least significant DATA_WIDTH bits.
  typedef logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] warp_reg_t;

  // 'reg' is a keyword, so the register field is reg_num.
  typedef struct packed {
    warp_num_t warp;
    reg_num_t  reg_num;
    rs_num_t   rs;
  } reg_read_req_t;

endpackage

`default_nettype wire

// File: rtl/gelato_operand_bank_arbiter_reg_bank.sv
// ============================================================================
// gelato_reg_bank: one register-file bank, sync read, lane-masked write. Rev 1.0
// ============================================================================
`default_nettype none

module gelato_reg_bank
  import gelato_types::*;
#(
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             i_rd_en,
  input  logic [ROW_W-1:0] i_rd_row,
  output warp_reg_t        o_rd_data,
  input  logic             i_wr_en,
  input  logic [ROW_W-1:0] i_wr_row,
  input  thread_mask_t     i_wr_mask,
  input  warp_reg_t        i_wr_data
);

  warp_reg_t r_mem [2**ROW_W];
  warp_reg_t r_rd_data;

  // Storage is intentionally not reset; the read register only changes on a grant.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (i_wr_mask[t]) begin
          r_mem[i_wr_row][t] <= i_wr_data[t];
        end
      end
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_row];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/gelato_operand_bank_arbiter.sv
// ============================================================================
// gelato_operand_bank_arbiter: per-bank round-robin operand reads plus one
// writeback port into the banked register file. Rev 1.0
// ============================================================================
`default_nettype none

module gelato_operand_bank_arbiter
  import gelato_types::*;
#(
  parameter int NUM_COLLECTORS = 4,
  parameter int NUM_BANKS      = 4,
  parameter int NUM_REGS       = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_COLLECTORS-1:0] req_valid,
  output logic [NUM_COLLECTORS-1:0] req_ready,
  input  warp_num_t                 req_warp  [NUM_COLLECTORS],
  input  reg_num_t                  req_reg   [NUM_COLLECTORS],
  input  rs_num_t                   req_rs    [NUM_COLLECTORS],
  output logic [NUM_COLLECTORS-1:0] resp_valid,
  output rs_num_t                   resp_rs   [NUM_COLLECTORS],
  output warp_reg_t                 resp_data [NUM_COLLECTORS],
  input  logic                      wb_valid,
  input  warp_num_t                 wb_warp,
  input  reg_num_t                  wb_reg,
  input  thread_mask_t              wb_mask,
  input  warp_reg_t                 wb_data
);

  localparam int c_CW    = (NUM_COLLECTORS > 1) ? $clog2(NUM_COLLECTORS) : 1;
  localparam int c_BW    = $clog2(NUM_BANKS);
  localparam int c_RW    = $clog2(NUM_REGS);
  localparam int c_ROW_W = WARP_W + c_RW - c_BW;

  reg_read_req_t             w_req      [NUM_COLLECTORS];
  logic [c_BW-1:0]           w_req_bank [NUM_COLLECTORS];
  logic [c_ROW_W-1:0]        w_req_row  [NUM_COLLECTORS];
  logic [c_BW-1:0]           w_wb_bank;
  logic [c_ROW_W-1:0]        w_wb_row;

  logic [NUM_COLLECTORS-1:0] w_grant    [NUM_BANKS];
  logic [NUM_BANKS-1:0]      w_rd_en;
  logic [c_ROW_W-1:0]        w_rd_row   [NUM_BANKS];
  logic [c_CW-1:0]           w_ptr_nxt  [NUM_BANKS];
  warp_reg_t                 w_bank_rdata [NUM_BANKS];

  logic [c_CW-1:0]           r_ptr      [NUM_BANKS];
  logic [NUM_COLLECTORS-1:0] r_resp_valid;
  rs_num_t                   r_resp_rs   [NUM_COLLECTORS];
  logic [c_BW-1:0]           r_resp_bank [NUM_COLLECTORS];
  logic [NUM_COLLECTORS-1:0] r_resp_zero;

  // Bank = low bits of (reg + warp); only the low bits of each operand matter.
  always_comb begin
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      w_req[c]      = '{warp: req_warp[c], reg_num: req_reg[c], rs: req_rs[c]};
      w_req_bank[c] = w_req[c].reg_num[c_BW-1:0] + c_BW'(w_req[c].warp);
      w_req_row[c]  = {w_req[c].warp, w_req[c].reg_num[c_RW-1:c_BW]};
    end
    w_wb_bank = wb_reg[c_BW-1:0] + c_BW'(wb_warp);
    w_wb_row  = {wb_warp, wb_reg[c_RW-1:c_BW]};
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_grant[b]   = '0;
      w_rd_en[b]   = 1'b0;
      w_rd_row[b]  = '0;
      w_ptr_nxt[b] = r_ptr[b];
      if (rst_n && !(wb_valid && (w_wb_bank == c_BW'(b)))) begin
        for (int i = 0; i < NUM_COLLECTORS; i++) begin
          idx = (int'(r_ptr[b]) + i) % NUM_COLLECTORS;
          if (!w_rd_en[b] && req_valid[idx] && (w_req_bank[idx] == c_BW'(b))) begin
            w_rd_en[b]        = 1'b1;
            w_grant[b][idx]   = 1'b1;
            w_rd_row[b]       = w_req_row[idx];
            w_ptr_nxt[b]      = (idx == NUM_COLLECTORS - 1) ? '0 : c_CW'(idx + 1);
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      req_ready = req_ready | w_grant[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      r_resp_zero  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_ptr[b] <= '0;
      end
      for (int c = 0; c < NUM_COLLECTORS; c++) begin
        r_resp_rs[c]   <= '0;
        r_resp_bank[c] <= '0;
      end
    end else begin
      r_resp_valid <= req_ready;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_ptr[b] <= w_ptr_nxt[b];
      end
      for (int c = 0; c < NUM_COLLECTORS; c++) begin
        r_resp_rs[c]   <= req_ready[c] ? w_req[c].rs : '0;
        r_resp_bank[c] <= w_req_bank[c];
        r_resp_zero[c] <= (w_req[c].reg_num == '0);
      end
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      // Register-0 writes still claim the bank but never reach storage.
      gelato_reg_bank #(
        .ROW_W (c_ROW_W)
      ) u_bank (
        .clk       (clk),
        .i_rd_en   (w_rd_en[b]),
        .i_rd_row  (w_rd_row[b]),
        .o_rd_data (w_bank_rdata[b]),
        .i_wr_en   (wb_valid && (w_wb_bank == c_BW'(b)) && (wb_reg != '0)),
        .i_wr_row  (w_wb_row),
        .i_wr_mask (wb_mask),
        .i_wr_data (wb_data)
      );
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      resp_data[c] = (r_resp_valid[c] && !r_resp_zero[c]) ? w_bank_rdata[r_resp_bank[c]] : '0;
      resp_rs[c]   = r_resp_rs[c];
    end
    resp_valid = r_resp_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_gelato_operand_bank_arbiter.sv
// ============================================================================
// tb_gelato_operand_bank_arbiter: directed self-checking bench. Rev 1.0
// ============================================================================
`default_nettype none

module tb_gelato_operand_bank_arbiter;
  import gelato_types::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  warp_num_t    req_warp  [4];
  reg_num_t     req_reg   [4];
  rs_num_t      req_rs    [4];
  logic [3:0]   resp_valid;
  rs_num_t      resp_rs   [4];
  warp_reg_t    resp_data [4];
  logic         wb_valid;
  warp_num_t    wb_warp;
  reg_num_t     wb_reg;
  thread_mask_t wb_mask;
  warp_reg_t    wb_data;

  int checks = 0;
  int errors = 0;

  gelato_operand_bank_arbiter #(
    .NUM_COLLECTORS (4),
    .NUM_BANKS      (4),
    .NUM_REGS       (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_warp   (req_warp),
    .req_reg    (req_reg),
    .req_rs     (req_rs),
    .resp_valid (resp_valid),
    .resp_rs    (resp_rs),
    .resp_data  (resp_data),
    .wb_valid   (wb_valid),
    .wb_warp    (wb_warp),
    .wb_reg     (wb_reg),
    .wb_mask    (wb_mask),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input int w, input int r, input int rs);
    req_valid[c] = 1'b1;
    req_warp[c]  = warp_num_t'(w);
    req_reg[c]   = reg_num_t'(r);
    req_rs[c]    = rs_num_t'(rs);
  endtask

  task automatic do_wb(input int w, input int r, input logic [3:0] m, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_warp  = warp_num_t'(w);
    wb_reg   = reg_num_t'(r);
    wb_mask  = m;
    wb_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    wb_valid  = 1'b0;
    wb_warp   = '0;
    wb_reg    = '0;
    wb_mask   = '0;
    wb_data   = '0;
    for (int c = 0; c < 4; c++) set_req(c, 0, 4, 1);

    // Reset state, with requests pending
    tick(); tick(); #1;
    check("rst_ready",      32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rs0",   32'(resp_rs[0]), 32'h0);
    check("rst_resp_data0", resp_data[0], 32'h0);
    tick();
    rst_n     = 1'b1;
    req_valid = '0;

    // Basic read: w1 r5 -> bank 2
    tick();
    do_wb(1, 5, 4'hF, 32'hA5A5A5A5);
    tick();
    wb_valid = 1'b0;
    set_req(0, 1, 5, 2);
    #1;
    check("basic_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check("basic_resp_valid", 32'(resp_valid), 32'h1);
    check("basic_resp_rs",    32'(resp_rs[0]), 32'h2);
    check("basic_resp_data",  resp_data[0], 32'hA5A5A5A5);

    // Bank conflict: all four collectors on w0 r4 (bank 0)
    tick();
    do_wb(0, 4, 4'hF, 32'h3C3C3C3C);
    for (int k = 0; k < 5; k++) begin
      tick();
      wb_valid = 1'b0;
      for (int c = 0; c < 4; c++) set_req(c, 0, 4, 1);
      #1;
      check($sformatf("conflict_ready_%0d", k), 32'(req_ready), 32'h1 << (k % 4));
      check($sformatf("conflict_resp_%0d", k), 32'(resp_valid),
            (k == 0) ? 32'h0 : (32'h1 << ((k - 1) % 4)));
    end
    tick();
    req_valid = '0;
    #1;
    check("conflict_last_resp", 32'(resp_valid), 32'h1);
    check("conflict_data",      resp_data[0], 32'h3C3C3C3C);

    // Write priority on bank 1; bank 2 read proceeds in parallel
    tick();
    do_wb(0, 1, 4'hF, 32'h77777777);
    set_req(2, 0, 1, 3);
    set_req(0, 1, 5, 2);
    #1;
    check("wprio_ready_blocked", 32'(req_ready), 32'h1);
    tick();
    wb_valid     = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    check("wprio_ready_retry",  32'(req_ready), 32'h4);
    check("wprio_parallel_resp", 32'(resp_valid), 32'h1);
    check("wprio_parallel_data", resp_data[0], 32'hA5A5A5A5);
    tick();
    req_valid = '0;
    #1;
    check("wprio_resp_valid", 32'(resp_valid), 32'h4);
    check("wprio_resp_rs",    32'(resp_rs[2]), 32'h3);
    check("wprio_resp_data",  resp_data[2], 32'h77777777);

    // Masked write: lanes 0 and 2 take 0x11 over 0x22
    tick();
    do_wb(2, 3, 4'hF, 32'h22222222);
    tick();
    do_wb(2, 3, 4'b0101, 32'h11111111);
    tick();
    wb_valid = 1'b0;
    set_req(1, 2, 3, 1);
    #1;
    check("mask_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #1;
    check("mask_resp_valid", 32'(resp_valid), 32'h2);
    check("mask_resp_data",  resp_data[1], 32'h22112211);

    // Register 0: write dropped but bank still occupied
    tick();
    do_wb(3, 0, 4'hF, 32'hFFFFFFFF);
    set_req(3, 3, 0, 1);
    #1;
    check("r0_ready_blocked", 32'(req_ready), 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("r0_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    #1;
    check("r0_resp_valid", 32'(resp_valid), 32'h8);
    check("r0_resp_data",  resp_data[3], 32'h0);

    // Reset mid-flight: bank 0 pointer sits at 1 here, so c1 wins
    tick();
    set_req(1, 0, 4, 2);
    #1;
    check("mid_ready", 32'(req_ready), 32'h2);
    tick();
    for (int c = 0; c < 4; c++) set_req(c, 0, 4, 1);
    rst_n = 1'b0;
    #1;
    check("mid_resp_valid", 32'(resp_valid), 32'h0);
    check("mid_resp_rs1",   32'(resp_rs[1]), 32'h0);
    check("mid_resp_data1", resp_data[1], 32'h0);
    check("mid_ready_rst",  32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    check("post_rst_resp",  32'(resp_valid), 32'h0);
    tick();
    req_valid = '0;
    #1;
    check("post_rst_resp_valid", 32'(resp_valid), 32'h1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
